// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART receive path.
//   rx_state_e  : receiver FSM states
//   mid_of      : mid-bit sample point (clocks per bit / 2)
//   idle_limit  : idle-count saturation value (idle bits * clocks per bit)
//   cnt_width   : width of the bit-phase counter
//   idle_width  : width of the idle counter (must hold idle_limit itself)
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned mid_of(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int unsigned idle_limit(input int unsigned clks_per_bit,
                                               input int unsigned idle_bits);
        return idle_bits * clks_per_bit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    function automatic int unsigned idle_width(input int unsigned clks_per_bit,
                                               input int unsigned idle_bits);
        return $clog2(idle_bits * clks_per_bit + 1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-loader bundle.
//   rx_data_o   : last good byte, valid while rx_valid_o is high
//   rx_valid_o  : one-cycle good-byte strobe
//   frame_err_o : one-cycle framing-error strobe
//   busy_o      : receiver FSM not idle
//   idle_o      : line has been idle long enough to realign word packing
// master = receiver side, slave = consumer side.
interface uart_rx_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;
    logic       busy_o;
    logic       idle_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output frame_err_o,
        output busy_o,
        output idle_o
    );

    modport slave (
        input rx_data_o,
        input rx_valid_o,
        input frame_err_o,
        input busy_o,
        input idle_o
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-low reset, both flops load ResetVal
//   d   : asynchronous input
//   q   : synchronised output
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= ResetVal;
            q      <= ResetVal;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART byte receiver feeding the debug loader.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   uart_rxd : raw serial line, idle high, asynchronous
//   en       : receive enable; low holds the receiver idle
//   rx       : byte/error strobes, busy and line-idle indication (master side)
// Each bit is decided by a 3-sample majority around mid-bit; the stop bit
// returns to idle at its decision point so a slightly fast sender still fits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned IDLE_BITS    = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      uart_rxd,
    input  logic      en,
    uart_rx_if.master rx
);
    localparam int unsigned CntW  = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IdleW = idle_width(CLKS_PER_BIT, IDLE_BITS);
    localparam int unsigned Mid   = mid_of(CLKS_PER_BIT);

    localparam logic [CntW-1:0]  CntSamp0  = CntW'(Mid - 1);
    localparam logic [CntW-1:0]  CntSamp1  = CntW'(Mid);
    localparam logic [CntW-1:0]  CntDecide = CntW'(Mid + 1);
    localparam logic [CntW-1:0]  CntLast   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdleW-1:0] IdleLimit = IdleW'(idle_limit(CLKS_PER_BIT, IDLE_BITS));

    if (CLKS_PER_BIT < 8) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 8");
    end

    logic             rxs, prev_q;
    logic             fall, maj, decide, wrap;
    rx_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       shreg_q, shreg_d, data_q, data_d;
    logic             valid_q, valid_d, ferr_q, ferr_d;
    logic             pend_q, pend_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    sync_2ff #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (uart_rxd),
        .q  (rxs)
    );

    assign fall   = prev_q & ~rxs;
    assign decide = (cnt_q == CntDecide);
    assign wrap   = (cnt_q == CntLast);
    // Two stored samples plus the live one on the decision cycle.
    assign maj    = (samp_q[0] & samp_q[1]) | (rxs & (samp_q[0] | samp_q[1]));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        pend_d     = 1'b0;
        idle_cnt_d = '0;

        if (state_q inside {StStart, StData, StStop}) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CntSamp0) samp_d[0] = rxs;
            if (cnt_q == CntSamp1) samp_d[1] = rxs;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                // pend_q covers an edge that landed on the previous stop decision.
                if (en && !rxs && (fall || pend_q)) state_d = StStart;
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (wrap) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (decide) shreg_d[idx_q] = maj;
                if (wrap) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (decide) begin
                    if (maj) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        pend_d  = fall;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle || state_d == StBreak) cnt_d = '0;

        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
            pend_d  = 1'b0;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            data_d  = data_q;
        end

        if (state_q == StIdle && rxs && en) begin
            idle_cnt_d = (idle_cnt_q == IdleLimit) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            pend_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            prev_q     <= rxs;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            pend_q     <= pend_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign rx.rx_data_o   = data_q;
    assign rx.rx_valid_o  = valid_q;
    assign rx.frame_err_o = ferr_q;
    assign rx.busy_o      = (state_q != StIdle);
    assign rx.idle_o      = en & (idle_cnt_q == IdleLimit);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with CLKS_PER_BIT=16, IDLE_BITS=4.
// The model is a queue of expected frame outcomes plus the last good byte;
// one negedge process checks every strobe and the held data against it.
module tb_uart_rx;
    localparam int unsigned Cpb      = 16;
    localparam int unsigned IdleBits = 4;

    logic clk = 1'b0;
    logic rst;
    logic uart_rxd = 1'b1;
    logic en = 1'b0;

    uart_rx_if rx_if ();

    uart_rx #(
        .CLKS_PER_BIT(Cpb),
        .IDLE_BITS   (IdleBits)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rxd(uart_rxd),
        .en      (en),
        .rx      (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    bit         exp_err_q[$];
    logic [7:0] exp_data_q[$];
    logic [7:0] last_good = 8'h00;
    int         last_valid_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_err_q.push_back(1'b0);
        exp_data_q.push_back(b);
    endtask

    task automatic expect_ferr();
        exp_err_q.push_back(1'b1);
        exp_data_q.push_back(8'h00);
    endtask

    // Drive one 8N1 frame. per_x100 = bit period in clocks *100; stop_cycles>0
    // overrides the stop-bit length; spike_at inverts the line for one cycle.
    task automatic send_frame(input logic [7:0] data, input int per_x100, input logic stop_val,
                              input int stop_cycles, input int spike_at, output int n0);
        logic [9:0] bits;
        bits = {stop_val, data, 1'b0};
        n0   = cyc;
        for (int i = 0; i < 10; i++) begin
            int b0, b1;
            b0 = (i * per_x100 + 50) / 100;
            b1 = (i == 9 && stop_cycles > 0) ? b0 + stop_cycles
                                              : ((i + 1) * per_x100 + 50) / 100;
            for (int k = b0; k < b1; k++) begin
                uart_rxd = (k == spike_at) ? ~bits[i] : bits[i];
                step(1);
            end
        end
        uart_rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("strobes exclusive", 32'(rx_if.rx_valid_o & rx_if.frame_err_o), 32'd0);
            if (rx_if.rx_valid_o) begin
                last_valid_cyc = cyc;
                if (exp_err_q.size() == 0) begin
                    check("spurious rx_valid_o", 32'(rx_if.rx_valid_o), 32'd0);
                end else begin
                    check("rx_valid_o vs expected good frame", 32'(rx_if.rx_valid_o),
                          32'(!exp_err_q[0]));
                    if (!exp_err_q[0]) begin
                        check("rx_data_o at strobe", 32'(rx_if.rx_data_o), 32'(exp_data_q[0]));
                        last_good = exp_data_q[0];
                    end
                    void'(exp_err_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
            end else if (rx_if.frame_err_o) begin
                if (exp_err_q.size() == 0) begin
                    check("spurious frame_err_o", 32'(rx_if.frame_err_o), 32'd0);
                end else begin
                    check("frame_err_o vs expected bad frame", 32'(rx_if.frame_err_o),
                          32'(exp_err_q[0]));
                    void'(exp_err_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
            end
            check("rx_data_o hold", 32'(rx_if.rx_data_o), 32'(last_good));
        end
    end

    initial begin
        int n0;
        rst = 1'b1;
        #1 rst = 1'b0;
        step(3);
        check("reset rx_data_o", 32'(rx_if.rx_data_o), 32'h00);
        check("reset rx_valid_o", 32'(rx_if.rx_valid_o), 32'd0);
        check("reset frame_err_o", 32'(rx_if.frame_err_o), 32'd0);
        check("reset busy_o", 32'(rx_if.busy_o), 32'd0);
        check("reset idle_o", 32'(rx_if.idle_o), 32'd0);

        // Line idle from release: idle_o rises on the 64th idle cycle.
        en  = 1'b1;
        rst = 1'b1;
        step(63);
        check("idle_o before limit", 32'(rx_if.idle_o), 32'd0);
        step(1);
        check("idle_o at limit", 32'(rx_if.idle_o), 32'd1);
        step(10);

        // Exact-baud 0xA5, strobe exactly 155 cycles after detect (detect = drive + 2).
        expect_byte(8'hA5);
        send_frame(8'hA5, 1600, 1'b1, 0, -1, n0);
        check("idle_o cleared by frame", 32'(rx_if.idle_o), 32'd0);
        step(20);
        check("0xA5 strobe cycle", 32'(last_valid_cyc), 32'(n0 + 157));

        // 0x55 with a one-cycle spike at the mid sample of bit 3.
        expect_byte(8'h55);
        send_frame(8'h55, 1600, 1'b1, 0, 73, n0);
        step(20);
        check("0x55 strobe cycle", 32'(last_valid_cyc), 32'(n0 + 157));

        // 4-cycle low glitch: START entered, then rejected.
        n0 = cyc;
        uart_rxd = 1'b0;
        step(4);
        uart_rxd = 1'b1;
        step(2);
        check("glitch busy_o high", 32'(rx_if.busy_o), 32'd1);
        step(14);
        check("glitch busy_o back low", 32'(rx_if.busy_o), 32'd0);
        step(10);

        // 0x81 with stop held low for 3 bit-times, then 0x12.
        expect_ferr();
        send_frame(8'h81, 1600, 1'b0, 48, -1, n0);
        step(30);
        check("break exited", 32'(rx_if.busy_o), 32'd0);
        expect_byte(8'h12);
        send_frame(8'h12, 1600, 1'b1, 0, -1, n0);
        step(20);

        // Back-to-back 0x00, 0xFF from a 4% fast sender.
        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, 1536, 1'b1, 0, -1, n0);
        send_frame(8'hFF, 1536, 1'b1, 0, -1, n0);
        step(40);

        // Drop en during DATA: frame dropped, idle_o held low.
        fork
            send_frame(8'h5A, 1600, 1'b1, 0, -1, n0);
            begin
                step(40);
                en = 1'b0;
                step(1);
                check("en low busy_o", 32'(rx_if.busy_o), 32'd0);
            end
        join
        step(80);
        check("en low idle_o forced", 32'(rx_if.idle_o), 32'd0);
        en = 1'b1;
        step(63);
        check("idle_o after en before limit", 32'(rx_if.idle_o), 32'd0);
        step(1);
        check("idle_o after en at limit", 32'(rx_if.idle_o), 32'd1);

        // Reset mid-frame, then 0x3C.
        uart_rxd = 1'b0;
        step(40);
        last_good = 8'h00;
        rst = 1'b0;
        #1;
        check("mid-frame reset rx_data_o", 32'(rx_if.rx_data_o), 32'h00);
        check("mid-frame reset rx_valid_o", 32'(rx_if.rx_valid_o), 32'd0);
        check("mid-frame reset frame_err_o", 32'(rx_if.frame_err_o), 32'd0);
        check("mid-frame reset busy_o", 32'(rx_if.busy_o), 32'd0);
        check("mid-frame reset idle_o", 32'(rx_if.idle_o), 32'd0);
        uart_rxd = 1'b1;
        step(5);
        rst = 1'b1;
        step(20);
        expect_byte(8'h3C);
        send_frame(8'h3C, 1600, 1'b1, 0, -1, n0);
        step(20);
        check("0x3C strobe cycle", 32'(last_valid_cyc), 32'(n0 + 157));

        step(100);
        check("expected strobes all seen", 32'(exp_err_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
